// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the router register block.
//   phase_e    - packet phase tracked by router_reg_p
//   CHK_XOR/CRC - check engine mode selectors
//   DEF_*      - default byte and address field widths
package router_pkg;
    typedef enum logic [2:0] {PH_IDLE, PH_HDR, PH_PAY, PH_CHK, PH_DONE} phase_e;
    localparam int CHK_XOR    = 0;
    localparam int CHK_CRC    = 1;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;
endpackage

// File: rtl/router_chk.sv
// router_chk: running packet check, XOR parity or MSB-first bytewise CRC.
//   clock, resetn - rising-edge clock, async active-low reset
//   clr           - restart the check at zero (wins over en)
//   en, byte_in   - fold byte_in into the running check
//   chk           - current check value
module router_chk
    import router_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                CHK_MODE = CHK_XOR,
    parameter logic [DATA_W-1:0] CRC_POLY = DATA_W'(8'h07)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] byte_in,
    output logic [DATA_W-1:0] chk
);
    logic [DATA_W-1:0] chk_q, chk_d;

    function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = c ^ b;
        if (CHK_MODE == CHK_CRC)
            for (int i = 0; i < DATA_W; i++)
                r = r[DATA_W-1] ? (r << 1) ^ CRC_POLY : r << 1;
        return r;
    endfunction

    always_comb chk_d = clr ? '0 : en ? fold(chk_q, byte_in) : chk_q;

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) chk_q <= '0;
        else         chk_q <= chk_d;

    assign chk = chk_q;
endmodule

// File: rtl/router_reg_p.sv
// router_reg_p: router datapath register block - header latch, FIFO byte
// staging, packet check and length verification.
//   clock, resetn      - rising-edge clock, async active-low reset
//   pkt_valid, data_in - incoming packet byte
//   fifo_full          - downstream FIFO cannot accept a byte
//   detect_add, lfd_state, ld_state, laf_state, full_state - FSM strobes
//   rst_int_reg        - clears low_packet_valid
//   dout               - byte to FIFO (one cycle latency)
//   err, len_err       - check / payload length mismatch of last packet
//   parity_done, low_packet_valid, hdr_len - packet status and length field
module router_reg_p
    import router_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                CHK_MODE = CHK_XOR,
    parameter logic [DATA_W-1:0] CRC_POLY = DATA_W'(8'h07)
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     pkt_valid,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     fifo_full,
    input  logic                     detect_add,
    input  logic                     lfd_state,
    input  logic                     ld_state,
    input  logic                     laf_state,
    input  logic                     full_state,
    input  logic                     rst_int_reg,
    output logic [DATA_W-1:0]        dout,
    output logic                     err,
    output logic                     len_err,
    output logic                     parity_done,
    output logic                     low_packet_valid,
    output logic [DATA_W-ADDR_W-1:0] hdr_len
);
    localparam int LEN_W = DATA_W - ADDR_W;

    phase_e              phase_q, phase_d;
    logic [DATA_W-1:0]   dout_q, dout_d, hold_hdr_q, hold_hdr_d, full_byte_q, full_byte_d;
    logic [DATA_W-1:0]   received_q, received_d, chk;
    logic [LEN_W-1:0]    count_q, count_d;
    logic                err_q, err_d, len_err_q, len_err_d, pd_q, pd_d, pd_prev_q, lpv_q, lpv_d;
    logic                hdr_go, fold_pay, chk_end, pd_rise;

    router_chk #(.DATA_W(DATA_W), .CHK_MODE(CHK_MODE), .CRC_POLY(CRC_POLY)) u_chk (
        .clock  (clock),
        .resetn (resetn),
        .clr    (detect_add),
        .en     (lfd_state | fold_pay),
        .byte_in(lfd_state ? hold_hdr_q : data_in),
        .chk    (chk)
    );

    always_comb begin
        hdr_go      = detect_add & pkt_valid;
        fold_pay    = ld_state & pkt_valid & !full_state;
        chk_end     = ld_state & !pkt_valid;
        // err/len_err sample the finished check one cycle after parity_done rises
        pd_rise     = pd_q & !pd_prev_q;
        hold_hdr_d  = hdr_go ? data_in : hold_hdr_q;
        dout_d      = lfd_state ? hold_hdr_q : (ld_state & !fifo_full) ? data_in : laf_state ? full_byte_q : dout_q;
        // a byte refused by a full FIFO is parked here and replayed in laf_state
        full_byte_d = (ld_state & fifo_full) ? data_in : full_byte_q;
        received_d  = chk_end ? data_in : received_q;
        count_d     = detect_add ? '0 : (fold_pay && count_q != '1) ? count_q + 1'b1 : count_q;
        pd_d        = detect_add ? 1'b0 : ((chk_end & !fifo_full) | (laf_state & lpv_q & !pd_q)) ? 1'b1 : pd_q;
        lpv_d       = rst_int_reg ? 1'b0 : chk_end ? 1'b1 : lpv_q;
        err_d       = detect_add ? 1'b0 : pd_rise ? (chk != received_q) : err_q;
        len_err_d   = detect_add ? 1'b0 : pd_rise ? (count_q != hdr_len) : len_err_q;
        phase_d     = hdr_go                            ? PH_HDR  :
                      (phase_q == PH_HDR  && lfd_state)  ? PH_PAY  :
                      (phase_q == PH_PAY  && chk_end)    ? PH_CHK  :
                      (phase_q == PH_CHK  && pd_q)       ? PH_DONE :
                      detect_add                         ? PH_IDLE : phase_q;
    end

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            phase_q     <= PH_IDLE;
            dout_q      <= '0;
            hold_hdr_q  <= '0;
            full_byte_q <= '0;
            received_q  <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            len_err_q   <= 1'b0;
            pd_q        <= 1'b0;
            pd_prev_q   <= 1'b0;
            lpv_q       <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            dout_q      <= dout_d;
            hold_hdr_q  <= hold_hdr_d;
            full_byte_q <= full_byte_d;
            received_q  <= received_d;
            count_q     <= count_d;
            err_q       <= err_d;
            len_err_q   <= len_err_d;
            pd_q        <= pd_d;
            pd_prev_q   <= pd_q;
            lpv_q       <= lpv_d;
        end

    assign dout             = dout_q;
    assign err              = err_q;
    assign len_err          = len_err_q;
    assign parity_done      = pd_q;
    assign low_packet_valid = lpv_q;
    assign hdr_len          = hold_hdr_q[DATA_W-1:ADDR_W];
endmodule
